packet_request_port: RTL

- Input-side requester of the 4x4 switch; it is the counterpart of the per-output round-robin arbiter.
- Buffers bytes arriving on one input link and frames them into packets using the header length.
- Presents a one-hot destination request plus the packet length to the output arbiters.
- When granted, streams the head packet out one byte per cycle, so the arbiter's 16-bit down counter and this block's stream end together.

---
 rtl/packet_request_port.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/packet_request_port.sv
// Input-side requester for the 4x4 switch.
// Buffers bytes from one input link, frames them into packets using the header
// length field, and requests the head packet's output port from the arbiters.
// When granted, the head packet streams out one byte per cycle with no gaps.
module packet_request_port #(
    parameter int PORT_ID = 1,
    parameter int DEPTH   = 128,
    parameter int AW      = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [3:0]  req_dest,
    output logic [15:0] req_len,
    input  logic        grant,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    // Out-of-range parameters elaborate an empty marker block so they are easy
    // to spot in the elaborated hierarchy; PORT_ID itself drives no logic.
    if (PORT_ID < 1 || PORT_ID > 4 || DEPTH != (1 << AW) || DEPTH < 65) begin : g_bad_params
    end

    logic [7:0]  mem [DEPTH];

    state_t      state_reg, state_next;
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0] pkt_cnt_reg, pkt_cnt_next;
    logic        in_pkt_reg;
    logic [5:0]  remain_reg;
    logic [5:0]  send_left_reg;
    logic        out_valid_reg, out_sop_reg, out_eop_reg;
    logic [7:0]  out_data_reg;

    logic        full, wr_en, wr_done, eop_now;
    logic        rd_en, start_send;
    logic [7:0]  head_byte;
    logic [15:0] head_len;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign in_ready = ~full;
    assign wr_en    = in_valid & ~full;

    // A packet completes on its last byte; a zero-length header completes itself.
    assign wr_done  = wr_en && (in_pkt_reg ? (remain_reg == 6'd1) : (in_data[5:0] == 6'd0));
    assign eop_now  = (state_reg == SEND) && out_eop_reg;

    // Show-ahead view of the head of the buffer; in REQ this is the header.
    assign head_byte = mem[rd_ptr_reg[AW-1:0]];
    assign head_len  = {10'd0, head_byte[5:0]} + 16'd1;

    assign req_len   = (state_reg == REQ) ? head_len : 16'd0;
    assign busy      = (state_reg == SEND);
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sop   = out_sop_reg;
    assign out_eop   = out_eop_reg;

    // One-hot destination request, only while waiting for a grant.
    for (genvar gi = 0; gi < 4; gi++) begin : g_req_dest
        assign req_dest[gi] = (state_reg == REQ) && (head_byte[7:6] == 2'(gi));
    end

    // Byte storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= in_data;
        end
    end

    // Write pointer and packet framer tracking header / payload position.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            in_pkt_reg <= 1'b0;
            remain_reg <= 6'd0;
        end else if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + CNT_ONE;
            if (!in_pkt_reg) begin
                if (in_data[5:0] != 6'd0) begin
                    in_pkt_reg <= 1'b1;
                    remain_reg <= in_data[5:0];
                end
            end else begin
                remain_reg <= remain_reg - 6'd1;
                if (remain_reg == 6'd1) begin
                    in_pkt_reg <= 1'b0;
                end
            end
        end
    end

    // Count of fully buffered packets: up on write completion, down on eop.
    always_comb begin
        pkt_cnt_next = pkt_cnt_reg;
        case ({wr_done, eop_now})
            2'b10:   pkt_cnt_next = pkt_cnt_reg + CNT_ONE;
            2'b01:   pkt_cnt_next = pkt_cnt_reg - CNT_ONE;
            default: pkt_cnt_next = pkt_cnt_reg;
        endcase
    end

    // Packet counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_reg <= '0;
        end else begin
            pkt_cnt_reg <= pkt_cnt_next;
        end
    end

    // FSM next state and read strobes.
    always_comb begin
        state_next = state_reg;
        rd_en      = 1'b0;
        start_send = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (pkt_cnt_reg != '0) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (grant) begin
                    start_send = 1'b1;
                    rd_en      = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (send_left_reg != 6'd0) begin
                    rd_en = 1'b1;
                end else begin
                    // The eop byte is on the output this cycle.
                    state_next = (pkt_cnt_next != '0) ? REQ : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Read pointer and registered output byte stream.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg    <= '0;
            send_left_reg <= 6'd0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= 8'd0;
            out_sop_reg   <= 1'b0;
            out_eop_reg   <= 1'b0;
        end else begin
            out_valid_reg <= rd_en;
            if (rd_en) begin
                out_data_reg <= head_byte;
                rd_ptr_reg   <= rd_ptr_reg + CNT_ONE;
                out_sop_reg  <= start_send;
                if (start_send) begin
                    send_left_reg <= head_byte[5:0];
                    out_eop_reg   <= (head_byte[5:0] == 6'd0);
                end else begin
                    send_left_reg <= send_left_reg - 6'd1;
                    out_eop_reg   <= (send_left_reg == 6'd1);
                end
            end else begin
                out_sop_reg <= 1'b0;
                out_eop_reg <= 1'b0;
            end
        end
    end

endmodule
